// File: rtl/pay_pkg.sv
// Shared definitions for the payment controller: display state codes,
// price table, coin values and tick-based timing constants.
package pay_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0000,
        ST_COIN    = 4'b0010,
        ST_SUCCESS = 4'b0110,
        ST_FAIL    = 4'b0111,
        ST_SOLDOUT = 4'b1000
    } state_t;

    localparam logic [6:0] PRICE_ID0 = 7'd3;
    localparam logic [6:0] PRICE_ID1 = 7'd4;
    localparam logic [6:0] PRICE_ID2 = 7'd5;
    localparam logic [6:0] PRICE_ID3 = 7'd6;

    localparam logic [7:0] COIN1_VAL = 8'd1;
    localparam logic [7:0] COIN5_VAL = 8'd5;
    localparam logic [7:0] PAID_MAX  = 8'd99;

    localparam logic [3:0] QTY_MIN = 4'd1;
    localparam logic [3:0] QTY_MAX = 4'd9;

    // Tick counts for the down-counter: payment window and result display hold.
    localparam logic [4:0] TIMEOUT_TICKS = 5'd30;
    localparam logic [4:0] HOLD_TICKS    = 5'd2;

    function automatic logic [6:0] price_of(input logic [1:0] id);
        logic [6:0] p;
        case (id)
            2'd0:    p = PRICE_ID0;
            2'd1:    p = PRICE_ID1;
            2'd2:    p = PRICE_ID2;
            default: p = PRICE_ID3;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] clamp_qty(input logic [3:0] q);
        logic [3:0] r;
        if (q < QTY_MIN)
            r = QTY_MIN;
        else if (q > QTY_MAX)
            r = QTY_MAX;
        else
            r = q;
        return r;
    endfunction

endpackage

// File: rtl/pay_fsm_if.sv
// Handshake and display bundle between the vending front end and pay_fsm.
interface pay_fsm_if;

    logic       tick_1s;
    logic       start;
    logic [1:0] id;
    logic [3:0] qty;
    logic [5:0] stock;
    logic       coin1;
    logic       coin5;
    logic       cancel;

    logic [3:0] state;
    logic [3:0] paid_tens;
    logic [3:0] paid_ones;
    logic [3:0] bill_tens;
    logic [3:0] bill_ones;
    logic [3:0] charge_tens;
    logic [3:0] charge_ones;
    logic       vend;
    logic [1:0] vend_id;
    logic [3:0] vend_qty;

    modport master (
        output tick_1s, start, id, qty, stock, coin1, coin5, cancel,
        input  state, paid_tens, paid_ones, bill_tens, bill_ones,
               charge_tens, charge_ones, vend, vend_id, vend_qty
    );

    modport slave (
        input  tick_1s, start, id, qty, stock, coin1, coin5, cancel,
        output state, paid_tens, paid_ones, bill_tens, bill_ones,
               charge_tens, charge_ones, vend, vend_id, vend_qty
    );

endinterface

// File: rtl/bin2bcd99.sv
// Binary 0..99 to two BCD digits; purely combinational so the digits
// follow their source register with no added latency.
module bin2bcd99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // Constant divide/modulo by ten over a 7-bit range.
    always_comb begin
        tens = 4'(bin / 7'd10);
        ones = 4'(bin % 7'd10);
    end

endmodule

// File: rtl/pay_fsm.sv
// Payment sequencer for the vending machine: prices the request, collects
// coins, vends or refunds, then holds the result on the display.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; amounts cleared
// ST_COIN    | collecting coins; cancel or 30-tick timeout refunds
// ST_SUCCESS | paid >= bill; vend pulsed on entry, change shown
// ST_FAIL    | cancelled or timed out; whole payment shown as refund
// ST_SOLDOUT | requested quantity exceeds stock
module pay_fsm
    import pay_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    pay_fsm_if.slave  bus
);

    state_t     state_q, state_d;
    logic [1:0] id_q, id_d;
    logic [3:0] qty_q, qty_d;
    logic [6:0] paid_q, paid_d;
    logic [6:0] bill_q, bill_d;
    logic [6:0] charge_q, charge_d;
    logic [4:0] tcnt_q, tcnt_d;
    logic       vend_q, vend_d;
    logic [1:0] vend_id_q, vend_id_d;
    logic [3:0] vend_qty_q, vend_qty_d;

    logic [3:0] qty_clamped;
    logic [6:0] bill_calc;
    logic [7:0] paid_sum;
    logic [6:0] paid_upd;
    logic       tick_tc;

    assign qty_clamped = clamp_qty(bus.qty);
    assign bill_calc   = price_of(bus.id) * {3'b000, qty_clamped};
    assign paid_sum    = {1'b0, paid_q}
                       + (bus.coin1 ? COIN1_VAL : 8'd0)
                       + (bus.coin5 ? COIN5_VAL : 8'd0);
    assign paid_upd    = (paid_sum > PAID_MAX) ? PAID_MAX[6:0] : paid_sum[6:0];
    // Terminal count of the shared down-counter on this cycle's tick.
    assign tick_tc     = bus.tick_1s && (tcnt_q == 5'd1);

    // Next-state and datapath decisions; completion beats cancel beats timeout.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        qty_d      = qty_q;
        paid_d     = paid_q;
        bill_d     = bill_q;
        charge_d   = charge_q;
        tcnt_d     = tcnt_q;
        vend_d     = 1'b0;
        vend_id_d  = 2'd0;
        vend_qty_d = 4'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    id_d     = bus.id;
                    qty_d    = qty_clamped;
                    bill_d   = bill_calc;
                    paid_d   = 7'd0;
                    charge_d = 7'd0;
                    if ({2'b00, qty_clamped} > bus.stock) begin
                        state_d = ST_SOLDOUT;
                        tcnt_d  = HOLD_TICKS;
                    end else begin
                        state_d = ST_COIN;
                        tcnt_d  = TIMEOUT_TICKS;
                    end
                end
            end

            ST_COIN: begin
                paid_d = paid_upd;
                if (paid_upd >= bill_q) begin
                    state_d    = ST_SUCCESS;
                    charge_d   = paid_upd - bill_q;
                    tcnt_d     = HOLD_TICKS;
                    vend_d     = 1'b1;
                    vend_id_d  = id_q;
                    vend_qty_d = qty_q;
                end else if (bus.cancel || tick_tc) begin
                    state_d  = ST_FAIL;
                    charge_d = paid_upd;
                    tcnt_d   = HOLD_TICKS;
                end else if (bus.tick_1s) begin
                    tcnt_d = tcnt_q - 5'd1;
                end
            end

            ST_SUCCESS, ST_FAIL, ST_SOLDOUT: begin
                if (tick_tc) begin
                    state_d  = ST_IDLE;
                    paid_d   = 7'd0;
                    bill_d   = 7'd0;
                    charge_d = 7'd0;
                    tcnt_d   = 5'd0;
                end else if (bus.tick_1s) begin
                    tcnt_d = tcnt_q - 5'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                paid_d   = 7'd0;
                bill_d   = 7'd0;
                charge_d = 7'd0;
                tcnt_d   = 5'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Amount, counter and vend registers; reset drops any payment in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q       <= 2'd0;
            qty_q      <= 4'd0;
            paid_q     <= 7'd0;
            bill_q     <= 7'd0;
            charge_q   <= 7'd0;
            tcnt_q     <= 5'd0;
            vend_q     <= 1'b0;
            vend_id_q  <= 2'd0;
            vend_qty_q <= 4'd0;
        end else begin
            id_q       <= id_d;
            qty_q      <= qty_d;
            paid_q     <= paid_d;
            bill_q     <= bill_d;
            charge_q   <= charge_d;
            tcnt_q     <= tcnt_d;
            vend_q     <= vend_d;
            vend_id_q  <= vend_id_d;
            vend_qty_q <= vend_qty_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.vend     = vend_q;
    assign bus.vend_id  = vend_id_q;
    assign bus.vend_qty = vend_qty_q;

    bin2bcd99 u_paid_bcd (
        .bin  (paid_q),
        .tens (bus.paid_tens),
        .ones (bus.paid_ones)
    );

    bin2bcd99 u_bill_bcd (
        .bin  (bill_q),
        .tens (bus.bill_tens),
        .ones (bus.bill_ones)
    );

    bin2bcd99 u_charge_bcd (
        .bin  (charge_q),
        .tens (bus.charge_tens),
        .ones (bus.charge_ones)
    );

endmodule

// File: tb/tb_pay_fsm.sv
// Scoreboard bench for pay_fsm: the driver predicts each purchase outcome
// from the pricing/payment rules and queues it; a monitor compares when the
// DUT enters a result state.
module tb_pay_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    pay_fsm_if bus ();

    pay_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] C_IDLE = 4'b0000;
    localparam logic [3:0] C_COIN = 4'b0010;
    localparam logic [3:0] C_SUCC = 4'b0110;
    localparam logic [3:0] C_FAIL = 4'b0111;
    localparam logic [3:0] C_SOLD = 4'b1000;

    int price_tb [4] = '{3, 4, 5, 6};

    typedef struct {
        logic [3:0] code;
        int         charge;
        int         paid;
        int         bill;
        bit         vend;
        int         vid;
        int         vqty;
    } exp_t;

    exp_t expq [$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int dig(input logic [3:0] t, input logic [3:0] o);
        return int'({t, o});
    endfunction

    // Monitor: pop an expectation whenever the DUT enters a result state.
    logic [3:0] prev_state = C_IDLE;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_state = C_IDLE;
        end else begin
            if (bus.state != prev_state &&
                (bus.state == C_SUCC || bus.state == C_FAIL || bus.state == C_SOLD)) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got state %0d expected none", bus.state);
                end else begin
                    e = expq.pop_front();
                    check("result_state", int'(bus.state), int'(e.code));
                    check("charge_bcd", dig(bus.charge_tens, bus.charge_ones), bcd(e.charge));
                    check("paid_bcd", dig(bus.paid_tens, bus.paid_ones), bcd(e.paid));
                    check("bill_bcd", dig(bus.bill_tens, bus.bill_ones), bcd(e.bill));
                    check("vend", int'(bus.vend), int'(e.vend));
                    if (e.vend) begin
                        check("vend_id", int'(bus.vend_id), e.vid);
                        check("vend_qty", int'(bus.vend_qty), e.vqty);
                    end
                end
            end else if (bus.vend) begin
                tests++;
                fails++;
                $display("FAIL stray_vend: got vend 1 in state %0d expected 0", bus.state);
            end
            prev_state = bus.state;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit c1, input bit c5, input bit cx, input bit tk, input bit st);
        bus.coin1   = c1;
        bus.coin5   = c5;
        bus.cancel  = cx;
        bus.tick_1s = tk;
        bus.start   = st;
        cyc();
        bus.coin1   = 1'b0;
        bus.coin5   = 1'b0;
        bus.cancel  = 1'b0;
        bus.tick_1s = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic pick(input int mode, input int k,
                        output bit c1, output bit c5, output bit cx,
                        output bit tk, output bit st);
        c1 = 0; c5 = 0; cx = 0; tk = 0; st = 0;
        case (mode)
            0: begin
                c1 = ($urandom_range(0, 9) < 3);
                c5 = ($urandom_range(0, 9) < 2);
                cx = ($urandom_range(0, 49) == 0);
                tk = ($urandom_range(0, 9) == 0);
                st = ($urandom_range(0, 19) == 0);
            end
            1: c5 = 1;
            2: begin
                c1 = (k == 0);
                tk = (k > 0);
            end
            3: begin
                c1 = (k == 0);
                c5 = 1;
                cx = (k == 1);
            end
            default: begin
                c1 = ($urandom_range(0, 19) == 0);
                tk = ($urandom_range(0, 1) == 1);
            end
        endcase
    endtask

    task automatic hold_phase(input logic [3:0] code);
        for (int t = 0; t < 2; t++) begin
            repeat ($urandom_range(0, 3))
                pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0, 1'b0);
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
            if (t == 0) begin
                check("hold_after_one_tick", int'(bus.state), int'(code));
            end else begin
                check("idle_after_two_ticks", int'(bus.state), int'(C_IDLE));
                check("idle_paid_clear", dig(bus.paid_tens, bus.paid_ones), 0);
                check("idle_bill_clear", dig(bus.bill_tens, bus.bill_ones), 0);
                check("idle_charge_clear", dig(bus.charge_tens, bus.charge_ones), 0);
            end
        end
    endtask

    // One purchase: predict the outcome from the payment rules, drive it, hold.
    task automatic run_txn(input int mode, input logic [1:0] tid,
                           input logic [3:0] tq, input logic [5:0] tst);
        int   qc, bill, paid, ticks, k;
        bit   done, c1, c5, cx, tk, st;
        exp_t e;
        qc    = (tq == 0) ? 1 : ((tq > 9) ? 9 : int'(tq));
        bill  = price_tb[tid] * qc;
        paid  = 0;
        ticks = 0;
        k     = 0;
        done  = 0;
        bus.id    = tid;
        bus.qty   = tq;
        bus.stock = tst;
        if (qc > int'(tst)) begin
            e = '{C_SOLD, 0, 0, bill, 1'b0, 0, 0};
            expq.push_back(e);
            pulse((mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            hold_phase(C_SOLD);
            return;
        end
        pulse((mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("coin_entry", int'(bus.state), int'(C_COIN));
        while (!done && k < 3000) begin
            pick(mode, k, c1, c5, cx, tk, st);
            paid = paid + int'(c1) + 5 * int'(c5);
            if (paid > 99) paid = 99;
            if (paid >= bill) begin
                e = '{C_SUCC, paid - bill, paid, bill, 1'b1, int'(tid), qc};
                done = 1;
            end else if (cx) begin
                e = '{C_FAIL, paid, paid, bill, 1'b0, 0, 0};
                done = 1;
            end else if (tk) begin
                ticks++;
                if (ticks == 30) begin
                    e = '{C_FAIL, paid, paid, bill, 1'b0, 0, 0};
                    done = 1;
                end
            end
            if (done) expq.push_back(e);
            if (st) begin
                bus.id    = 2'($urandom);
                bus.qty   = 4'($urandom);
                bus.stock = 6'($urandom);
            end
            pulse(c1, c5, cx, tk, st);
            if (mode == 3 && k == 0)
                check("paid_both_coins", dig(bus.paid_tens, bus.paid_ones), bcd(6));
            k++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL txn_bound: got no result after %0d cycles expected one", k);
            return;
        end
        hold_phase(e.code);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick_1s = 0; bus.start = 0; bus.id = 0; bus.qty = 0; bus.stock = 0;
        bus.coin1 = 0; bus.coin5 = 0; bus.cancel = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(bus.state), int'(C_IDLE));
        check("rst_vend", int'(bus.vend), 0);
        check("rst_paid", dig(bus.paid_tens, bus.paid_ones), 0);
        check("rst_bill", dig(bus.bill_tens, bus.bill_ones), 0);
        check("rst_charge", dig(bus.charge_tens, bus.charge_ones), 0);
        rst = 1'b0;

        run_txn(1, 2'd2, 4'd1, 6'd5);
        run_txn(1, 2'd3, 4'd2, 6'd20);
        run_txn(2, 2'd0, 4'd1, 6'd7);
        run_txn(0, 2'd1, 4'd4, 6'd3);
        run_txn(3, 2'd3, 4'd9, 6'd60);
        run_txn(1, 2'd1, 4'd0, 6'd0);
        run_txn(1, 2'd0, 4'd15, 6'd9);

        // Reset in the middle of a payment.
        bus.id = 2'd0; bus.qty = 4'd9; bus.stock = 6'd63;
        pulse(0, 0, 0, 0, 1);
        repeat (3) pulse(1, 0, 0, 0, 0);
        check("paid_before_reset", dig(bus.paid_tens, bus.paid_ones), bcd(3));
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", int'(bus.state), int'(C_IDLE));
        check("async_rst_paid", dig(bus.paid_tens, bus.paid_ones), 0);
        check("async_rst_bill", dig(bus.bill_tens, bus.bill_ones), 0);
        check("async_rst_charge", dig(bus.charge_tens, bus.charge_ones), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_vend", int'(bus.vend), 0);
        rst = 1'b0;
        run_txn(1, 2'd2, 4'd1, 6'd5);

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2))
                pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                      1'($urandom_range(0, 1)), 1'b0);
            run_txn(($urandom_range(0, 3) == 0) ? 5 : 0, 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 6'($urandom_range(0, 15)));
        end

        repeat (2) cyc();
        check("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pay_fsm.md
PAY_FSM -- requirements
Module: pay_fsm

Interface
REQ-001 The block SHALL have one clock, `clk`, with all state changing on its rising edge.
REQ-002 `rst`  in  1  The block SHALL use `rst` as an asynchronous, active-high reset.
REQ-003 `tick_1s`  in  1  One-cycle pulse, once per second.
REQ-004 `start`  in  1  Pulse requesting purchase of the selected item.
REQ-005 `id`  in  2  Selected item; sampled on `start`.
REQ-006 `qty`  in  4  Requested quantity; sampled on `start`.
REQ-007 `stock`  in  6  Stock of the selected `id`; sampled on `start`.
REQ-008 `coin1`, `coin5`  in  1 each  Coin pulses worth 1 and 5 units.
REQ-009 `cancel`  in  1  Pulse aborting payment.
REQ-010 `state`  out  4  Display state code, consumed by the screen generator.
REQ-011 `paid_tens`, `paid_ones`, `bill_tens`, `bill_ones`, `charge_tens`, `charge_ones`  out  4 each  BCD digits of the amounts.
REQ-012 `vend`  out  1  One-cycle dispense pulse.
REQ-013 `vend_id`  out  2  Item being dispensed; valid with `vend`.
REQ-014 `vend_qty`  out  4  Quantity being dispensed; valid with `vend`.

Function
REQ-015 States and codes SHALL be: IDLE=0000, COIN=0010, SUCCESS=0110, FAIL=0111, SOLDOUT=1000; `state` SHALL output the registered code directly.
REQ-016 Prices SHALL be: id0=3, id1=4, id2=5, id3=6.
REQ-017 On `start` in IDLE, the block SHALL latch `id` and clamped `qty` (0 becomes 1, values above 9 become 9), and set bill = price*qty (maximum 54, 7-bit binary).
REQ-018 On that same `start`, if qty > `stock` the next state SHALL be SOLDOUT; otherwise it SHALL be COIN with paid = 0.
REQ-019 `start` outside IDLE SHALL be ignored.
REQ-020 In COIN, each cycle paid SHALL increase by coin1*1 + coin5*5; both coins in one cycle add 6; paid saturates at 99.
REQ-021 Coins outside COIN SHALL be ignored.
REQ-022 In COIN, when the updated paid >= bill, the block SHALL go to SUCCESS on the next edge, set charge = paid - bill, and pulse `vend` for exactly one cycle with `vend_id`/`vend_qty`.
REQ-023 In COIN, `cancel` SHALL send the block to FAIL with charge = paid, counting any coin in the same cycle, and no `vend`.
REQ-024 In COIN, a tick counter cleared on entry SHALL count `tick_1s`; reaching 30 with paid < bill SHALL send the block to FAIL with full refund.
REQ-025 Priority in a single cycle SHALL be: payment completion > cancel > timeout.
REQ-026 SUCCESS, FAIL and SOLDOUT SHALL each hold for 2 `tick_1s` pulses counted after entry, then return to IDLE.
REQ-027 On return to IDLE, paid, bill and charge SHALL clear to 0.
REQ-028 BCD outputs SHALL be combinational conversions of the registered binary values, giving zero latency from the register update.
REQ-029 In IDLE, FAIL and SOLDOUT, `charge_*` SHALL show the charge register (0 unless refunded).

Reset
REQ-030 While `rst` is high, state SHALL be IDLE; paid, bill, charge, tick counter, `vend`, `vend_id` and `vend_qty` SHALL be 0; all BCD outputs SHALL be 0.
REQ-031 Reset asserted mid-COIN SHALL discard paid with no refund indication and no `vend`.
REQ-032 The first `start` after reset deassertion SHALL be honoured.

Structure
REQ-033 The package `pay_pkg` SHALL hold the state codes, the price table, the coin values, the timeout (30) and the display hold time (2).
REQ-034 The sub-module `bin2bcd99` (7-bit binary 0..99 to tens/ones BCD) SHALL be instantiated three times: paid, bill and charge.

Verification
REQ-035 id=2, qty=1, stock=5, start, then one coin5 -> state 0010, then 0110; charge 0/0; `vend`=1 for one cycle with vend_id=2; IDLE after 2 ticks.
REQ-036 id=3, qty=2 (bill 1/2), three coin5 -> paid 1/5, SUCCESS, charge 0/3, vend_qty=2.
REQ-037 id=0, qty=1, one coin1 at bill 3, then 30 ticks -> FAIL (0111), charge 0/1, no `vend`; IDLE after 2 more ticks.
REQ-038 qty=4, stock=3, start -> SOLDOUT (1000) for 2 ticks, then IDLE; coins during SOLDOUT are ignored.
REQ-039 id=3, qty=9 (bill 54): coin1 and coin5 in the same cycle give paid 6; a coin5 in the same cycle as `cancel` gives FAIL with charge 1/1.
REQ-040 After paid reaches 3, assert `rst` mid-COIN -> state 0000 and all digits 0 asynchronously, with no `vend` pulse.
